// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
//
// Sequencing stage around a shared WIDTH-bit combinational adder core. Multi-
// word operands arrive least-significant word first, one word per valid/ready
// beat. Each word is held in an operand register (S1) that drives the core.
// The core's sum/cout is captured into a result register (S2), and the
// carry-out is chained into the next word's carry-in. Subtraction is done as
// A + ~B + ~borrow_in.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    upstream beat handshake
//   in_a, in_b           operand words
//   in_first, in_last    operation framing
//   in_sub, in_cin       operation mode and carry/borrow-in (first beat only)
//   add_a/add_b/add_cin  to the adder core
//   add_sum/add_cout     from the adder core
//   out_valid/out_ready  downstream result handshake
//   out_sum, out_idx     result word and its index within the operation
//   out_last, out_cout   last-word flag and raw core carry-out
//   out_ovf              signed overflow (last word only)
//   err                  one-cycle protocol-error pulse
// ---------------------------------------------------------------------------
module multiword_add_seq #(
  parameter int WIDTH     = 20,
  parameter int MAX_WORDS = 8,
  parameter int IDXW      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MAX_WORDS - 1);

  // Input-side operation tracking
  logic [0:0]      state_q, state_d;
  logic            sub_q, sub_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            err_q, err_d;

  // S1 operand register
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_cin_q, s1_cin_d;
  logic             s1_sub_q, s1_sub_d;
  logic [IDXW-1:0]  s1_idx_q, s1_idx_d;
  logic             s1_last_q, s1_last_d;

  // S2 result register
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
  logic [IDXW-1:0]  s2_idx_q, s2_idx_d;
  logic             s2_last_q, s2_last_d;
  logic             s2_cout_q, s2_cout_d;
  logic             s2_ovf_q, s2_ovf_d;

  logic            s2_free;
  logic            s1_adv;
  logic            accept;
  logic            start;
  logic [IDXW-1:0] beat_idx;
  logic            beat_sub;
  logic            beat_cap;
  logic            beat_last;
  logic            beat_err;
  logic            beat_cin;
  logic            ovf;

  assign s2_free = ~s2_valid_q | out_ready;
  assign s1_adv  = s1_valid_q & s2_free;
  // Held low during reset so nothing is offered upstream before the flops settle.
  assign in_ready = rst_n & (~s1_valid_q | s1_adv);
  assign accept   = in_valid & in_ready;

  // A beat starts a new operation when we are idle (even without in_first,
  // which is then flagged) or when in_first arrives mid-operation.
  assign start    = (state_q == ST_IDLE) | in_first;
  assign beat_idx = start ? '0 : idx_q + 1'b1;
  assign beat_sub = start ? in_sub : sub_q;
  assign beat_cap = ~start & (beat_idx == LAST_IDX) & ~in_last;
  assign beat_last = in_last | beat_cap;
  assign beat_err  = ((state_q == ST_IDLE) & ~in_first)
                   | ((state_q == ST_BUSY) & in_first)
                   | beat_cap;
  // For subtract the borrow-in becomes an inverted carry-in.
  assign beat_cin  = in_sub ? ~in_cin : in_cin;

  assign add_a   = s1_a_q;
  assign add_b   = s1_sub_q ? ~s1_b_q : s1_b_q;
  assign add_cin = s1_first_q ? s1_cin_q : carry_q;

  // Signed overflow: carry into the MSB (sum^a^b at the MSB) differs from carry out.
  assign ovf = s1_last_q & (add_cout ^ (add_sum[WIDTH-1] ^ add_a[WIDTH-1] ^ add_b[WIDTH-1]));

  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_idx   = s2_idx_q;
  assign out_last  = s2_last_q;
  assign out_cout  = s2_cout_q;
  assign out_ovf   = s2_ovf_q;
  assign err       = err_q;

  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    err_d      = 1'b0;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_first_d = s1_first_q;
    s1_cin_d   = s1_cin_q;
    s1_sub_d   = s1_sub_q;
    s1_idx_d   = s1_idx_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_idx_d   = s2_idx_q;
    s2_last_d  = s2_last_q;
    s2_cout_d  = s2_cout_q;
    s2_ovf_d   = s2_ovf_q;

    // Each word carries its own sub/first/last flags in S1, so words of an
    // abandoned operation still drain with the flags they were accepted with.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_first_d = start;
      s1_cin_d   = beat_cin;
      s1_sub_d   = beat_sub;
      s1_idx_d   = beat_idx;
      s1_last_d  = beat_last;
      sub_d      = beat_sub;
      idx_d      = beat_idx;
      state_d    = beat_last ? ST_IDLE : ST_BUSY;
      err_d      = beat_err;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_sum_d   = add_sum;
      s2_idx_d   = s1_idx_q;
      s2_last_d  = s1_last_q;
      s2_cout_d  = add_cout;
      s2_ovf_d   = ovf;
      carry_d    = add_cout;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sub_q      <= 1'b0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_first_q <= 1'b0;
      s1_cin_q   <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_idx_q   <= '0;
      s2_last_q  <= 1'b0;
      s2_cout_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_first_q <= s1_first_d;
      s1_cin_q   <= s1_cin_d;
      s1_sub_q   <= s1_sub_d;
      s1_idx_q   <= s1_idx_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_idx_q   <= s2_idx_d;
      s2_last_q  <= s2_last_d;
      s2_cout_q  <= s2_cout_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// tb_multiword_add_seq
//
// Directed bench for multiword_add_seq. A behavioural 20-bit adder stands in
// for the core. Result beats are collected into a queue and compared against
// hand-computed expected words; a few cycle-exact checks probe latency,
// core-side drive, err timing, backpressure and reset.
// ---------------------------------------------------------------------------
module tb_multiword_add_seq;

  localparam int WIDTH     = 20;
  localparam int MAX_WORDS = 8;
  localparam int IDXW      = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_first = 1'b0;
  logic             in_last = 1'b0;
  logic             in_sub = 1'b0;
  logic             in_cin = 1'b0;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_cout;
  logic             out_ovf;
  logic             err;

  int checkCount = 0;
  int passCount  = 0;
  int errCount   = 0;

  logic [31:0] obsQ[$];
  logic [31:0] expQ[$];

  multiword_add_seq #(
    .WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS), .IDXW(IDXW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last),
    .in_sub(in_sub), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
    .out_cout(out_cout), .out_ovf(out_ovf),
    .err(err)
  );

  // Stand-in for the combinational adder core
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  always #5 clk = ~clk;

  // Record every consumed result beat and every err-high cycle
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      obsQ.push_back({6'd0, out_sum, out_idx, out_last, out_cout, out_ovf});
    if (rst_n && err)
      errCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp)
      passCount++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expectWord(input logic [WIDTH-1:0] sum, input logic [IDXW-1:0] idx,
                            input logic last, input logic cout, input logic ovf);
    expQ.push_back({6'd0, sum, idx, last, cout, ovf});
  endtask

  // Drive one beat and hold it until accepted (bounded); returns 1 time unit after the accept edge
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic first, input logic last,
                               input logic sub, input logic cin);
    logic accepted;
    logic readyNow;
    int   cyc;
    in_a = a; in_b = b; in_first = first; in_last = last; in_sub = sub; in_cin = cin;
    in_valid = 1'b1;
    accepted = 1'b0;
    cyc = 0;
    while (!accepted && cyc < 50) begin
      @(negedge clk);
      readyNow = in_ready;
      @(posedge clk);
      #1;
      if (readyNow) accepted = 1'b1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Wait (bounded) for all expected words, then compare count and contents
  task automatic checkResults(input string name);
    int cyc;
    int n;
    cyc = 0;
    while (obsQ.size() < expQ.size() && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput($sformatf("%s_count", name), obsQ.size(), expQ.size());
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_word%0d", name, i), obsQ[i], expQ[i]);
    obsQ.delete();
    expQ.delete();
  endtask

  initial begin
    int errBase;
    int c;

    // Reset
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_out_sum", out_sum, 0);
    #29 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", in_ready, 1);

    // Single add with signed overflow, 2-edge latency
    applyStimulus(20'h7FFFF, 20'h00001, 1, 1, 0, 0);
    checkOutput("single_add_a", add_a, 32'h7FFFF);
    checkOutput("single_add_cin", add_cin, 0);
    checkOutput("single_early_valid", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("single_valid", out_valid, 1);
    checkOutput("single_sum", out_sum, 32'h80000);
    checkOutput("single_ovf", out_ovf, 1);
    expectWord(20'h80000, 0, 1, 0, 1);
    checkResults("single");

    // Two-word carry chain
    applyStimulus(20'hFFFFF, 20'h00001, 1, 0, 0, 0);
    applyStimulus(20'h00000, 20'h00000, 0, 1, 0, 0);
    expectWord(20'h00000, 0, 0, 1, 0);
    expectWord(20'h00001, 1, 1, 0, 0);
    checkResults("chain");

    // Subtract 5 - 7
    applyStimulus(20'h00005, 20'h00007, 1, 1, 1, 0);
    checkOutput("sub_add_b", add_b, 32'hFFFF8);
    checkOutput("sub_add_cin", add_cin, 1);
    expectWord(20'hFFFFE, 0, 1, 0, 0);
    checkResults("sub");

    // Backpressure: 3-word add, out_ready low for 4 cycles after first output
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(20'hFFFFF, 20'hFFFFF, 1, 0, 0, 0);
        applyStimulus(20'h12345, 20'h0FFFF, 0, 0, 0, 0);
        applyStimulus(20'h80000, 20'h80000, 0, 1, 0, 0);
      end
      begin
        c = 0;
        while (!out_valid && c < 50) begin
          @(negedge clk);
          c++;
        end
        checkOutput("bp_in_ready_full", in_ready, 0);
        checkOutput("bp_first_sum", out_sum, 32'hFFFFE);
        repeat (3) @(negedge clk);
        checkOutput("bp_sum_stable", out_sum, 32'hFFFFE);
        checkOutput("bp_in_ready_stall", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    expectWord(20'hFFFFE, 0, 0, 1, 0);
    expectWord(20'h22345, 1, 0, 0, 0);
    expectWord(20'h00000, 2, 1, 1, 1);
    checkResults("bp");

    // Protocol error: in_first mid-operation restarts with in_cin
    errBase = errCount;
    applyStimulus(20'h00001, 20'h00001, 1, 0, 0, 0);
    applyStimulus(20'h00010, 20'h00020, 1, 1, 0, 1);
    checkOutput("restart_err_pulse", err, 1);
    @(posedge clk); #1;
    checkOutput("restart_err_clear", err, 0);
    expectWord(20'h00002, 0, 0, 0, 0);
    expectWord(20'h00031, 0, 1, 0, 0);
    checkResults("restart");
    checkOutput("restart_err_count", errCount - errBase, 1);

    // Word cap: 9 beats without in_last
    errBase = errCount;
    applyStimulus(20'hFFFFF, 20'h00000, 1, 0, 0, 1);
    expectWord(20'h00000, 0, 0, 1, 0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(20'hFFFFF, 20'h00000, 0, 0, 0, 0);
      expectWord(20'h00000, IDXW'(i), (i == 7), 1, 0);
    end
    applyStimulus(20'hFFFFF, 20'h00000, 0, 0, 0, 0);
    expectWord(20'hFFFFF, 0, 0, 0, 0);
    applyStimulus(20'h00000, 20'h00000, 0, 1, 0, 0);
    expectWord(20'h00000, 1, 1, 0, 0);
    checkResults("cap");
    checkOutput("cap_err_count", errCount - errBase, 2);

    // Reset with S1 and S2 both full
    out_ready = 1'b0;
    applyStimulus(20'h11111, 20'h22222, 1, 0, 0, 0);
    applyStimulus(20'h33333, 20'h44444, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_out_sum", out_sum, 0);
    #10 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    errBase = errCount;
    applyStimulus(20'h00003, 20'h00004, 1, 1, 0, 0);
    applyStimulus(20'h00001, 20'h00002, 1, 0, 0, 0);
    applyStimulus(20'h00005, 20'h00006, 0, 1, 0, 0);
    expectWord(20'h00007, 0, 1, 0, 0);
    expectWord(20'h00003, 0, 0, 0, 0);
    expectWord(20'h0000B, 1, 1, 0, 0);
    checkResults("postrst");
    checkOutput("postrst_err_count", errCount - errBase, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
